// File: rtl/keyboard_mk2.sv
// Scancode-to-matrix keyboard front end: loadable scancode map, aliased matrix counts,
// modifier/alpha/turbo state, typematic repeat and a buffered event FIFO.
module keyboard_mk2 #(
    parameter int SCAN_W     = 7,
    parameter int NUM_KEYS   = 48,
    parameter int KIDX_W     = 6,
    parameter int NUM_MODS   = 4,
    parameter logic [NUM_MODS*8-1:0] MOD_CODES = {8'h3a, 8'h3d, 8'h34, 8'h0f},
    parameter logic [SCAN_W-1:0] ALPHA_CODE = 7'h48,
    parameter logic [SCAN_W-1:0] TURBO_CODE = 7'h40,
    parameter int FIFO_DEPTH = 8,
    parameter int REP_FIRST  = 1023,
    parameter int REP_NEXT   = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SCAN_W-1:0]   scancode,
    input  logic                trigger,
    input  logic                pressed,
    input  logic                keyboard_block,
    input  logic                tick,
    input  logic                map_we,
    input  logic [SCAN_W-1:0]   map_addr,
    input  logic [KIDX_W:0]     map_data,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_MODS-1:0] mod_state,
    output logic                alpha_state,
    output logic                turbo_state,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [SCAN_W-1:0]   ev_code,
    output logic [NUM_MODS-1:0] ev_mods,
    output logic                ev_repeat,
    output logic                ev_overflow,
    input  logic                ovf_clr
);
    localparam int NCODES = 2 ** SCAN_W;
    localparam int EV_W   = 1 + NUM_MODS + SCAN_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int REP_W  = $clog2(REP_FIRST + 1);
    localparam logic [KIDX_W:0]  NK       = KIDX_W'(NUM_KEYS);
    localparam logic [REP_W-1:0] REP_F    = REP_W'(REP_FIRST);
    localparam logic [REP_W-1:0] REP_N    = REP_W'(REP_NEXT);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [KIDX_W:0]     r_map [NCODES];
    logic [NCODES-1:0]   r_held;
    logic [1:0]          r_cnt [NUM_KEYS];
    logic [NUM_MODS-1:0] r_mod;
    logic                r_alpha;
    logic                r_turbo;
    logic                r_rep_armed;
    logic [SCAN_W-1:0]   r_rep_code;
    logic [REP_W-1:0]    r_rep_cnt;
    logic [EV_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_ovf;

    logic                w_new_make;
    logic                w_break;
    logic [NUM_MODS-1:0] w_mod_hit;
    logic                w_is_alpha;
    logic                w_is_turbo;
    logic                w_special;
    logic [KIDX_W-1:0]   w_idx;
    logic                w_map_ok;
    logic                w_rep_fire;
    logic                w_push;
    logic [EV_W-1:0]     w_push_data;
    logic                w_pop;
    logic                w_full;
    logic                w_do_push;
    logic                w_drop;
    logic [NUM_KEYS-1:0] w_keys;

    // Map lookups read the registered table, so a same-cycle map write is not seen.
    always_comb begin
        w_new_make = trigger & pressed & ~r_held[scancode];
        w_break    = trigger & ~pressed & r_held[scancode];
        w_mod_hit  = '0;
        for (int k = 0; k < NUM_MODS; k++)
            w_mod_hit[k] = (scancode == MOD_CODES[(NUM_MODS-1-k)*8 +: SCAN_W]);
        w_is_alpha = (scancode == ALPHA_CODE);
        w_is_turbo = (scancode == TURBO_CODE);
        w_special  = (|w_mod_hit) | w_is_alpha | w_is_turbo;
        w_idx      = r_map[scancode][KIDX_W-1:0];
        w_map_ok   = r_map[scancode][KIDX_W] && ({1'b0, w_idx} < NK);
        w_rep_fire = ~trigger & tick & r_rep_armed & (r_rep_cnt == REP_W'(1));
        w_push      = 1'b0;
        w_push_data = '0;
        if (w_new_make && !w_special) begin
            w_push      = 1'b1;
            w_push_data = {1'b0, r_mod, scancode};
        end else if (w_rep_fire) begin
            w_push      = 1'b1;
            w_push_data = {1'b1, r_mod, r_rep_code};
        end
        w_pop     = (r_count != '0) & ev_ready;
        w_full    = (r_count == FULL_CNT);
        w_do_push = w_push & (~w_full | w_pop);
        w_drop    = w_push & w_full & ~w_pop;
        w_keys    = '0;
        for (int k = 0; k < NUM_KEYS; k++)
            w_keys[k] = (r_cnt[k] != 2'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCODES; i++) r_map[i] <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_cnt[k] <= 2'd0;
            r_held      <= '0;
            r_mod       <= '0;
            r_alpha     <= 1'b0;
            r_turbo     <= 1'b0;
            r_rep_armed <= 1'b0;
            r_rep_code  <= '0;
            r_rep_cnt   <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (map_we) r_map[map_addr] <= map_data;
            if (w_new_make) begin
                r_held[scancode] <= 1'b1;
                r_mod <= r_mod | w_mod_hit;
                if (w_is_alpha) r_alpha <= 1'b1;
                if (w_is_turbo) r_turbo <= ~r_turbo;
                if (w_map_ok && !keyboard_block && r_cnt[w_idx] != 2'd3)
                    r_cnt[w_idx] <= r_cnt[w_idx] + 2'd1;
                if (!w_special) begin
                    r_rep_armed <= 1'b1;
                    r_rep_code  <= scancode;
                    r_rep_cnt   <= REP_F;
                end
            end else if (w_break) begin
                r_held[scancode] <= 1'b0;
                r_mod <= r_mod & ~w_mod_hit;
                if (w_is_alpha) r_alpha <= 1'b0;
                if (w_map_ok && r_cnt[w_idx] != 2'd0)
                    r_cnt[w_idx] <= r_cnt[w_idx] - 2'd1;
                if (r_rep_armed && r_rep_code == scancode) r_rep_armed <= 1'b0;
            end else if (!trigger && tick && r_rep_armed) begin
                r_rep_cnt <= w_rep_fire ? REP_N : r_rep_cnt - REP_W'(1);
            end
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
            if (w_do_push && !w_pop) r_count <= r_count + CNT_W'(1);
            else if (w_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
            // A drop wins over a simultaneous clear so the loss is never hidden.
            if (w_drop) r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr] <= w_push_data;
    end

    assign key_state   = w_keys;
    assign mod_state   = r_mod;
    assign alpha_state = r_alpha;
    assign turbo_state = r_turbo;
    assign ev_valid    = (r_count != '0);
    assign ev_overflow = r_ovf;
    assign {ev_repeat, ev_mods, ev_code} = ev_valid ? r_mem[r_rptr] : '0;
endmodule

// File: tb/tb_keyboard_mk2.sv
// Directed bench for keyboard_mk2: expected events queue on issue, a monitor pops on handshake.
module tb_keyboard_mk2;
    localparam int SCAN_W = 7;
    localparam int KIDX_W = 6;
    localparam int NUM_KEYS = 48;
    localparam int NUM_MODS = 4;
    localparam int EV_W = 1 + NUM_MODS + SCAN_W;

    logic                clk = 1'b0;
    logic                reset;
    logic [SCAN_W-1:0]   scancode;
    logic                trigger, pressed, keyboard_block, tick, map_we;
    logic [SCAN_W-1:0]   map_addr;
    logic [KIDX_W:0]     map_data;
    logic [NUM_KEYS-1:0] key_state;
    logic [NUM_MODS-1:0] mod_state;
    logic                alpha_state, turbo_state, ev_valid, ev_ready;
    logic [SCAN_W-1:0]   ev_code;
    logic [NUM_MODS-1:0] ev_mods;
    logic                ev_repeat, ev_overflow, ovf_clr;

    int tests = 0;
    int fails = 0;
    int ev_seen = 0;
    int rep_seen = 0;
    int base;
    logic [EV_W-1:0] exp_q[$];

    keyboard_mk2 dut (
        .clk(clk), .reset(reset), .scancode(scancode), .trigger(trigger), .pressed(pressed),
        .keyboard_block(keyboard_block), .tick(tick), .map_we(map_we), .map_addr(map_addr),
        .map_data(map_data), .key_state(key_state), .mod_state(mod_state),
        .alpha_state(alpha_state), .turbo_state(turbo_state), .ev_valid(ev_valid),
        .ev_ready(ev_ready), .ev_code(ev_code), .ev_mods(ev_mods), .ev_repeat(ev_repeat),
        .ev_overflow(ev_overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head event must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ev_valid && ev_ready) begin
            tests++;
            ev_seen++;
            if (ev_repeat) rep_seen++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event: got %0h expected none", {ev_repeat, ev_mods, ev_code});
            end else begin
                logic [EV_W-1:0] e;
                e = exp_q.pop_front();
                if ({ev_repeat, ev_mods, ev_code} !== e) begin
                    fails++;
                    $display("FAIL event: got %0h expected %0h", {ev_repeat, ev_mods, ev_code}, e);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [SCAN_W-1:0] code, input logic pr);
        @(posedge clk); #1;
        scancode = code; pressed = pr; trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic map_wr(input logic [SCAN_W-1:0] addr, input logic [KIDX_W-1:0] idx);
        @(posedge clk); #1;
        map_addr = addr; map_data = {1'b1, idx}; map_we = 1'b1;
        @(posedge clk); #1;
        map_we = 1'b0;
    endtask

    task automatic ticks(input int n);
        @(posedge clk); #1;
        tick = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic expect_ev(input logic rep, input logic [NUM_MODS-1:0] mods, input logic [SCAN_W-1:0] code);
        exp_q.push_back({rep, mods, code});
    endtask

    initial begin
        reset = 1'b1; scancode = '0; trigger = 0; pressed = 0; keyboard_block = 0; tick = 0;
        map_we = 0; map_addr = '0; map_data = '0; ev_ready = 1'b1; ovf_clr = 0;
        idle(3);
        reset = 1'b0;
        idle(1);
        check("rst_keys", key_state, 0);
        check("rst_mods", mod_state, 0);
        check("rst_alpha_turbo", {alpha_state, turbo_state}, 0);
        check("rst_ev", {ev_valid, ev_overflow}, 0);

        map_wr(7'h0f, 6'd5);
        map_wr(7'h34, 6'd5);
        map_wr(7'h1c, 6'd39);
        map_wr(7'h28, 6'd0);

        // Two aliases sharing index 5
        key(7'h0f, 1);
        key(7'h34, 1);
        check("alias_mods", mod_state, 4'b1100);
        key(7'h0f, 0);
        check("alias_key5_held", key_state[5], 1);
        check("alias_mods_after", mod_state, 4'b0100);
        key(7'h34, 0);
        check("alias_key5_free", key_state[5], 0);

        // Typematic repeat timing
        expect_ev(0, 0, 7'h1c);
        key(7'h1c, 1);
        check("rep_key39", key_state[39], 1);
        idle(2);
        base = rep_seen;
        ticks(1022);
        idle(2);
        check("rep_not_early", rep_seen - base, 0);
        expect_ev(1, 0, 7'h1c);
        ticks(1);
        idle(2);
        check("rep_first", rep_seen - base, 1);
        ticks(254);
        idle(2);
        check("rep_next_not_early", rep_seen - base, 1);
        expect_ev(1, 0, 7'h1c);
        ticks(1);
        idle(2);
        check("rep_second", rep_seen - base, 2);
        expect_ev(1, 0, 7'h1c);
        ticks(255);
        idle(2);
        check("rep_third", rep_seen - base, 3);
        key(7'h1c, 0);
        check("rep_key39_up", key_state[39], 0);
        ticks(300);
        idle(2);
        check("rep_cancelled", rep_seen - base, 3);

        // keyboard_block suppresses the press, release must not underflow
        keyboard_block = 1'b1;
        expect_ev(0, 0, 7'h28);
        key(7'h28, 1);
        check("blk_key0", key_state[0], 0);
        keyboard_block = 1'b0;
        key(7'h28, 0);
        check("blk_break_key0", key_state[0], 0);
        expect_ev(0, 0, 7'h28);
        key(7'h28, 1);
        check("blk_remake_key0", key_state[0], 1);
        key(7'h28, 0);
        check("blk_rebreak_key0", key_state[0], 0);

        // Turbo toggle and alpha level
        key(7'h40, 1);
        check("turbo_on", turbo_state, 1);
        key(7'h40, 1);
        check("turbo_autorep", turbo_state, 1);
        key(7'h40, 0);
        key(7'h40, 1);
        check("turbo_off", turbo_state, 0);
        key(7'h40, 0);
        key(7'h48, 1);
        check("alpha_on", alpha_state, 1);
        key(7'h48, 0);
        check("alpha_off", alpha_state, 0);
        idle(2);
        check("special_no_events", exp_q.size(), 0);

        // FIFO overflow, modifier 0 held while filling
        ev_ready = 1'b0;
        key(7'h3a, 1);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) expect_ev(0, 4'b0001, 7'h50 + 7'(i));
            key(7'h50 + 7'(i), 1);
        end
        check("ovf_set", ev_overflow, 1);
        check("ovf_valid", ev_valid, 1);
        base = ev_seen;
        ev_ready = 1'b1;
        for (int i = 0; i < 40 && ev_valid; i++) idle(1);
        idle(1);
        check("ovf_drained_count", ev_seen - base, 8);
        check("ovf_sticky", ev_overflow, 1);
        @(posedge clk); #1 ovf_clr = 1'b1;
        @(posedge clk); #1 ovf_clr = 1'b0;
        check("ovf_cleared", ev_overflow, 0);
        for (int i = 0; i < 9; i++) key(7'h50 + 7'(i), 0);
        key(7'h3a, 0);

        // Reset mid-operation
        ev_ready = 1'b0;
        key(7'h3a, 1);
        key(7'h40, 1);
        key(7'h60, 1);
        key(7'h61, 1);
        key(7'h1c, 1);
        check("pre_rst_state", {ev_valid, turbo_state, mod_state[0], key_state[39]}, 4'b1111);
        @(posedge clk); #1 reset = 1'b1;
        #2;
        check("mid_rst_keys", key_state, 0);
        check("mid_rst_mods", {mod_state, alpha_state, turbo_state}, 0);
        check("mid_rst_ev", {ev_valid, ev_overflow, ev_code, ev_mods, ev_repeat}, 0);
        @(posedge clk); #1 reset = 1'b0;
        key(7'h1c, 1);
        check("post_rst_map_invalid", key_state, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
